axi2per_res_channel: RTL and testbench

//  Response stage of the AXI-to-peripheral bridge; sits directly upstream of the R buffer.

---
 rtl/axi2per_res_channel.sv | 186 ++++++++++++++++++
 tb/tb_axi2per_res_channel.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2per_res_channel.sv
// Response stage of the AXI-to-peripheral bridge: tracks one outstanding peripheral
// transaction and turns its response into a registered AXI R beat or B response.
module axi2per_res_channel #(
  parameter int PER_ADDR_WIDTH = 32,
  parameter int PER_DATA_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      per_master_r_valid_i,
  input  logic                      per_master_r_opc_i,
  input  logic [PER_DATA_WIDTH-1:0] per_master_r_rdata_i,

  input  logic                      trans_req_i,
  input  logic                      trans_we_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [PER_ADDR_WIDTH-1:0] trans_add_i,
  input  logic [AXI_USER_WIDTH-1:0] trans_user_i,
  input  logic                      trans_last_i,
  output logic                      trans_ready_o,

  output logic                      axi_slave_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
  output logic [1:0]                axi_slave_r_resp_o,
  output logic                      axi_slave_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o,
  input  logic                      axi_slave_r_ready_i,

  output logic                      axi_slave_b_valid_o,
  output logic [1:0]                axi_slave_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o,
  input  logic                      axi_slave_b_ready_i
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESP,
    SEND_R,
    SEND_B
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic                      r_we;
  logic                      r_lane;
  logic                      r_last;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_wr_err;

  logic                      r_rvalid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_rresp;
  logic                      r_rlast;
  logic [AXI_ID_WIDTH-1:0]   r_rid;
  logic [AXI_USER_WIDTH-1:0] r_ruser;

  logic                      r_bvalid;
  logic [1:0]                r_bresp;
  logic [AXI_ID_WIDTH-1:0]   r_bid;
  logic [AXI_USER_WIDTH-1:0] r_buser;

  logic w_accept;
  logic w_resp;
  logic w_r_hs;
  logic w_b_hs;
  logic w_unused_add;

  assign w_accept = (r_state == IDLE) && trans_req_i;
  assign w_resp   = (r_state == WAIT_RESP) && per_master_r_valid_i;
  assign w_r_hs   = (r_state == SEND_R) && axi_slave_r_ready_i;
  assign w_b_hs   = (r_state == SEND_B) && axi_slave_b_ready_i;

  // Only bit 2 of the address matters: it picks the 32-bit lane of the 64-bit beat.
  assign w_unused_add = ^{trans_add_i[PER_ADDR_WIDTH-1:3], trans_add_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (trans_req_i) w_next_state = WAIT_RESP;
      WAIT_RESP: begin
        if (per_master_r_valid_i) begin
          if (!r_we)       w_next_state = SEND_R;
          else if (r_last) w_next_state = SEND_B;
          else             w_next_state = IDLE;
        end
      end
      SEND_R:    if (axi_slave_r_ready_i) w_next_state = IDLE;
      SEND_B:    if (axi_slave_b_ready_i) w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we   <= 1'b0;
      r_lane <= 1'b0;
      r_last <= 1'b0;
      r_id   <= '0;
      r_user <= '0;
    end else if (w_accept) begin
      r_we   <= trans_we_i;
      r_lane <= trans_add_i[2];
      r_last <= trans_last_i;
      r_id   <= trans_id_i;
      r_user <= trans_user_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
      r_rlast  <= 1'b0;
      r_rid    <= '0;
      r_ruser  <= '0;
    end else if (w_resp && !r_we) begin
      r_rvalid <= 1'b1;
      r_rdata  <= r_lane ? {per_master_r_rdata_i, {PER_DATA_WIDTH{1'b0}}}
                         : {{PER_DATA_WIDTH{1'b0}}, per_master_r_rdata_i};
      r_rresp  <= per_master_r_opc_i ? 2'b10 : 2'b00;
      r_rlast  <= r_last;
      r_rid    <= r_id;
      r_ruser  <= r_user;
    end else if (w_r_hs) begin
      r_rvalid <= 1'b0;
    end
  end

  // Errors on non-last write beats accumulate so the single B of the burst reports them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
      r_bid    <= '0;
      r_buser  <= '0;
      r_wr_err <= 1'b0;
    end else if (w_resp && r_we) begin
      if (r_last) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (per_master_r_opc_i || r_wr_err) ? 2'b10 : 2'b00;
        r_bid    <= r_id;
        r_buser  <= r_user;
      end else begin
        r_wr_err <= r_wr_err | per_master_r_opc_i;
      end
    end else if (w_b_hs) begin
      r_bvalid <= 1'b0;
      r_wr_err <= 1'b0;
    end
  end

  assign trans_ready_o       = (r_state == IDLE);
  assign axi_slave_r_valid_o = r_rvalid;
  assign axi_slave_r_data_o  = r_rdata;
  assign axi_slave_r_resp_o  = r_rresp;
  assign axi_slave_r_last_o  = r_rlast;
  assign axi_slave_r_id_o    = r_rid;
  assign axi_slave_r_user_o  = r_ruser;
  assign axi_slave_b_valid_o = r_bvalid;
  assign axi_slave_b_resp_o  = r_bresp;
  assign axi_slave_b_id_o    = r_bid;
  assign axi_slave_b_user_o  = r_buser;

  // Protocol violations are ignored by the logic above; these only flag them in simulation.
  a_resp_in_wait : assert property (@(posedge clk_i) disable iff (!rst_ni)
      per_master_r_valid_i |-> (r_state == WAIT_RESP))
    else $warning("peripheral response outside WAIT_RESP ignored");

  a_req_in_idle : assert property (@(posedge clk_i) disable iff (!rst_ni)
      trans_req_i |-> (r_state == IDLE))
    else $warning("transaction request outside IDLE ignored");

endmodule

// File: tb/tb_axi2per_res_channel.sv
// Randomized self-checking bench for axi2per_res_channel against a transaction-level model.
module tb_axi2per_res_channel;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        per_master_r_valid_i;
  logic        per_master_r_opc_i;
  logic [31:0] per_master_r_rdata_i;
  logic        trans_req_i;
  logic        trans_we_i;
  logic [3:0]  trans_id_i;
  logic [31:0] trans_add_i;
  logic [5:0]  trans_user_i;
  logic        trans_last_i;
  logic        trans_ready_o;
  logic        axi_slave_r_valid_o;
  logic [63:0] axi_slave_r_data_o;
  logic [1:0]  axi_slave_r_resp_o;
  logic        axi_slave_r_last_o;
  logic [3:0]  axi_slave_r_id_o;
  logic [5:0]  axi_slave_r_user_o;
  logic        axi_slave_r_ready_i;
  logic        axi_slave_b_valid_o;
  logic [1:0]  axi_slave_b_resp_o;
  logic [3:0]  axi_slave_b_id_o;
  logic [5:0]  axi_slave_b_user_o;
  logic        axi_slave_b_ready_i;

  int totalChecks = 0;
  int badChecks   = 0;
  bit modelErr    = 1'b0;

  axi2per_res_channel dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .per_master_r_valid_i (per_master_r_valid_i),
    .per_master_r_opc_i   (per_master_r_opc_i),
    .per_master_r_rdata_i (per_master_r_rdata_i),
    .trans_req_i          (trans_req_i),
    .trans_we_i           (trans_we_i),
    .trans_id_i           (trans_id_i),
    .trans_add_i          (trans_add_i),
    .trans_user_i         (trans_user_i),
    .trans_last_i         (trans_last_i),
    .trans_ready_o        (trans_ready_o),
    .axi_slave_r_valid_o  (axi_slave_r_valid_o),
    .axi_slave_r_data_o   (axi_slave_r_data_o),
    .axi_slave_r_resp_o   (axi_slave_r_resp_o),
    .axi_slave_r_last_o   (axi_slave_r_last_o),
    .axi_slave_r_id_o     (axi_slave_r_id_o),
    .axi_slave_r_user_o   (axi_slave_r_user_o),
    .axi_slave_r_ready_i  (axi_slave_r_ready_i),
    .axi_slave_b_valid_o  (axi_slave_b_valid_o),
    .axi_slave_b_resp_o   (axi_slave_b_resp_o),
    .axi_slave_b_id_o     (axi_slave_b_id_o),
    .axi_slave_b_user_o   (axi_slave_b_user_o),
    .axi_slave_b_ready_i  (axi_slave_b_ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!trans_ready_o && n < 20) begin
      tick();
      n++;
    end
    checkOutput("idle_reached", trans_ready_o, 1);
  endtask

  // One complete transaction: request, response after respDelay cycles, then the
  // AXI channel is held not-ready for readyDelay cycles before the handshake.
  task automatic applyStimulus(input bit we, input logic [3:0] id, input logic [31:0] add,
                               input logic [5:0] user, input bit last, input bit opc,
                               input logic [31:0] rdata, input int respDelay, input int readyDelay);
    logic [63:0] expData;
    logic [1:0]  expResp;
    waitIdle();
    trans_req_i  = 1'b1;
    trans_we_i   = we;
    trans_id_i   = id;
    trans_add_i  = add;
    trans_user_i = user;
    trans_last_i = last;
    tick();
    trans_req_i  = 1'b0;
    trans_id_i   = $urandom;
    trans_add_i  = $urandom;
    trans_user_i = $urandom;
    trans_last_i = $urandom;
    trans_we_i   = $urandom;
    checkOutput("wait_ready", trans_ready_o, 0);
    for (int i = 0; i < respDelay; i++) begin
      tick();
      checkOutput("wait_no_out", {axi_slave_r_valid_o, axi_slave_b_valid_o}, 0);
    end
    per_master_r_valid_i = 1'b1;
    per_master_r_opc_i   = opc;
    per_master_r_rdata_i = rdata;
    tick();
    per_master_r_valid_i = 1'b0;
    per_master_r_rdata_i = $urandom;
    per_master_r_opc_i   = $urandom;

    if (!we) begin
      expData = 64'(rdata) << (add[2] ? 32 : 0);
      expResp = opc ? 2'b10 : 2'b00;
      checkOutput("b_quiet_on_read", axi_slave_b_valid_o, 0);
      for (int i = 0; i <= readyDelay; i++) begin
        checkOutput("r_valid", axi_slave_r_valid_o, 1);
        checkOutput("r_data", axi_slave_r_data_o, expData);
        checkOutput("r_resp", axi_slave_r_resp_o, expResp);
        checkOutput("r_last", axi_slave_r_last_o, last);
        checkOutput("r_id", axi_slave_r_id_o, id);
        checkOutput("r_user", axi_slave_r_user_o, user);
        checkOutput("r_busy", trans_ready_o, 0);
        if (i == readyDelay) axi_slave_r_ready_i = 1'b1;
        tick();
      end
      axi_slave_r_ready_i = 1'b0;
      checkOutput("r_done_valid", axi_slave_r_valid_o, 0);
      checkOutput("r_done_ready", trans_ready_o, 1);
    end else if (last) begin
      expResp  = (opc || modelErr) ? 2'b10 : 2'b00;
      modelErr = 1'b0;
      checkOutput("r_quiet_on_write", axi_slave_r_valid_o, 0);
      for (int i = 0; i <= readyDelay; i++) begin
        checkOutput("b_valid", axi_slave_b_valid_o, 1);
        checkOutput("b_resp", axi_slave_b_resp_o, expResp);
        checkOutput("b_id", axi_slave_b_id_o, id);
        checkOutput("b_user", axi_slave_b_user_o, user);
        checkOutput("b_busy", trans_ready_o, 0);
        if (i == readyDelay) axi_slave_b_ready_i = 1'b1;
        tick();
      end
      axi_slave_b_ready_i = 1'b0;
      checkOutput("b_done_valid", axi_slave_b_valid_o, 0);
      checkOutput("b_done_ready", trans_ready_o, 1);
    end else begin
      modelErr = modelErr | opc;
      checkOutput("nonlast_no_out", {axi_slave_r_valid_o, axi_slave_b_valid_o}, 0);
      checkOutput("nonlast_ready", trans_ready_o, 1);
    end
  endtask

  initial begin
    bit          we, last, opc;
    logic [31:0] add;
    rst_ni               = 1'b0;
    per_master_r_valid_i = 1'b0;
    per_master_r_opc_i   = 1'b0;
    per_master_r_rdata_i = '0;
    trans_req_i          = 1'b0;
    trans_we_i           = 1'b0;
    trans_id_i           = '0;
    trans_add_i          = '0;
    trans_user_i         = '0;
    trans_last_i         = 1'b0;
    axi_slave_r_ready_i  = 1'b0;
    axi_slave_b_ready_i  = 1'b0;

    #12;
    checkOutput("rst_ready", trans_ready_o, 1);
    checkOutput("rst_rvalid", axi_slave_r_valid_o, 0);
    checkOutput("rst_bvalid", axi_slave_b_valid_o, 0);
    checkOutput("rst_rdata", axi_slave_r_data_o, 0);
    checkOutput("rst_rmisc", {axi_slave_r_resp_o, axi_slave_r_last_o, axi_slave_r_id_o, axi_slave_r_user_o}, 0);
    checkOutput("rst_bmisc", {axi_slave_b_resp_o, axi_slave_b_id_o, axi_slave_b_user_o}, 0);
    rst_ni = 1'b1;
    tick();

    $display("[TB] directed reads");
    applyStimulus(1'b0, 4'd3, 32'h1000, 6'h11, 1'b1, 1'b0, 32'hDEADBEEF, 0, 0);
    applyStimulus(1'b0, 4'd5, 32'h1004, 6'h22, 1'b1, 1'b0, 32'h12345678, 0, 5);

    $display("[TB] write bursts");
    applyStimulus(1'b1, 4'd7, 32'h2000, 6'h01, 1'b0, 1'b0, 32'h0, 0, 0);
    applyStimulus(1'b1, 4'd7, 32'h2004, 6'h01, 1'b0, 1'b1, 32'h0, 1, 0);
    applyStimulus(1'b1, 4'd7, 32'h2008, 6'h01, 1'b0, 1'b0, 32'h0, 0, 0);
    applyStimulus(1'b1, 4'd7, 32'h200C, 6'h01, 1'b1, 1'b0, 32'h0, 0, 2);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 4'd9, 32'h3000 + 32'(i * 4), 6'h3F, i == 3, 1'b0, 32'h0, 0, 1);

    $display("[TB] error read and spurious response");
    applyStimulus(1'b0, 4'd1, 32'h0, 6'h05, 1'b0, 1'b1, 32'hCAFEF00D, 2, 1);
    per_master_r_valid_i = 1'b1;
    per_master_r_opc_i   = 1'b1;
    tick();
    per_master_r_valid_i = 1'b0;
    per_master_r_opc_i   = 1'b0;
    checkOutput("spurious_no_out", {axi_slave_r_valid_o, axi_slave_b_valid_o}, 0);
    checkOutput("spurious_ready", trans_ready_o, 1);
    applyStimulus(1'b1, 4'd2, 32'h40, 6'h06, 1'b1, 1'b0, 32'h0, 0, 0);

    $display("[TB] reset during SEND_R");
    trans_req_i  = 1'b1;
    trans_we_i   = 1'b0;
    trans_last_i = 1'b1;
    tick();
    trans_req_i          = 1'b0;
    per_master_r_valid_i = 1'b1;
    per_master_r_rdata_i = 32'hA5A5A5A5;
    tick();
    per_master_r_valid_i = 1'b0;
    tick();
    checkOutput("pre_rst_rvalid", axi_slave_r_valid_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_rst_rvalid", axi_slave_r_valid_o, 0);
    checkOutput("async_rst_rdata", axi_slave_r_data_o, 0);
    #3;
    rst_ni   = 1'b1;
    modelErr = 1'b0;
    tick();
    checkOutput("post_rst_ready", trans_ready_o, 1);

    $display("[TB] reset clears write error");
    applyStimulus(1'b1, 4'd4, 32'h0, 6'h0, 1'b0, 1'b1, 32'h0, 0, 0);
    rst_ni = 1'b0;
    #2;
    rst_ni   = 1'b1;
    modelErr = 1'b0;
    tick();
    applyStimulus(1'b1, 4'd4, 32'h4, 6'h0, 1'b1, 1'b0, 32'h0, 0, 0);

    $display("[TB] back-to-back reads, ready tied high");
    axi_slave_r_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = $urandom;
      checkOutput("b2b_ready", trans_ready_o, 1);
      trans_req_i  = 1'b1;
      trans_we_i   = 1'b0;
      trans_id_i   = 4'(i);
      trans_add_i  = 32'(i * 4);
      trans_last_i = (i == 3);
      tick();
      trans_req_i          = 1'b0;
      per_master_r_valid_i = 1'b1;
      per_master_r_rdata_i = d;
      tick();
      per_master_r_valid_i = 1'b0;
      checkOutput("b2b_rvalid", axi_slave_r_valid_o, 1);
      checkOutput("b2b_rdata", axi_slave_r_data_o, 64'(d) << ((i % 2) * 32));
      checkOutput("b2b_rid", axi_slave_r_id_o, 64'(i));
      tick();
      checkOutput("b2b_rvalid_low", axi_slave_r_valid_o, 0);
    end
    axi_slave_r_ready_i = 1'b0;

    $display("[TB] randomized transactions");
    for (int n = 0; n < 60; n++) begin
      we   = $urandom_range(0, 1);
      last = $urandom_range(0, 2) != 0;
      opc  = $urandom_range(0, 4) == 0;
      add  = $urandom;
      applyStimulus(we, 4'($urandom), add, 6'($urandom), last, opc, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
